// File: rtl/stage_mem_pkg.sv
// Shared types for the memory-access stage: FSM states, access sizes
// and the data-bus / write-back bundles.
package stage_mem_pkg;

   localparam int XLEN = 64;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT
   } mem_state_t;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   typedef struct packed {
      logic [XLEN-1:0] addr;
      logic            write;
      logic [7:0]      wstrb;
      logic [XLEN-1:0] wdata;
   } dbus_req;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] result;
      logic            misalign;
   } mem2wb;

   function automatic logic [7:0] size_mask(input logic [1:0] size);
      logic [7:0] m;
      unique case (size)
         SZ_B:    m = 8'h01;
         SZ_H:    m = 8'h03;
         SZ_W:    m = 8'h0f;
         default: m = 8'hff;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/stage_mem_align.sv
// Combinational lane logic: misalignment check on the incoming access,
// store lane shift/strobes and load shift/extension on the captured one.
module mem_align
   import stage_mem_pkg::*;
(
   input  logic [2:0]      chk_addr,
   input  logic [1:0]      chk_size,
   input  logic [2:0]      fmt_addr,
   input  logic [2:0]      fmt_funct3,
   input  logic            fmt_write,
   input  logic [XLEN-1:0] wdata,
   input  logic [XLEN-1:0] rdata,
   output logic            misalign,
   output logic [7:0]      lane_wstrb,
   output logic [XLEN-1:0] lane_wdata,
   output logic [XLEN-1:0] load_data
);

   logic [XLEN-1:0] shifted;
   logic            sx;

   always_comb begin
      unique case (chk_size)
         SZ_B:    misalign = 1'b0;
         SZ_H:    misalign = chk_addr[0];
         SZ_W:    misalign = |chk_addr[1:0];
         default: misalign = |chk_addr;
      endcase
   end

   assign lane_wdata = wdata << {fmt_addr, 3'b000};
   assign lane_wstrb = fmt_write ?
                       (size_mask(fmt_funct3[1:0]) << fmt_addr) : 8'h00;

   assign shifted = rdata >> {fmt_addr, 3'b000};
   assign sx      = ~fmt_funct3[2];

   always_comb begin
      unique case (fmt_funct3[1:0])
         SZ_B:    load_data = {{56{sx & shifted[7]}}, shifted[7:0]};
         SZ_H:    load_data = {{48{sx & shifted[15]}}, shifted[15:0]};
         SZ_W:    load_data = {{32{sx & shifted[31]}}, shifted[31:0]};
         default: load_data = shifted;
      endcase
   end

endmodule

// File: rtl/stage_mem.sv
// Memory-access stage: one load/store per instruction over a valid/ready
// data bus, with a registered write-back result and back-pressure.
module stage_mem
   import stage_mem_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            mem_flush,
   input  logic            in_valid,
   input  logic            in_mem_en,
   input  logic            in_mem_write,
   input  logic [2:0]      in_funct3,
   input  logic [XLEN-1:0] in_addr,
   input  logic [XLEN-1:0] in_wdata,
   input  logic [XLEN-1:0] in_alu_out,
   output logic            mem_ready,
   output logic            req_valid,
   input  logic            req_ready,
   output logic [XLEN-1:0] req_addr,
   output logic            req_write,
   output logic [7:0]      req_wstrb,
   output logic [XLEN-1:0] req_wdata,
   input  logic            resp_valid,
   input  logic [XLEN-1:0] resp_rdata,
   output logic            out_valid,
   output logic [XLEN-1:0] out_result,
   output logic            out_misalign
);

   mem_state_t      state_q, state_d;
   logic            kill_q, kill_d;
   logic            cap_en;
   logic [XLEN-1:0] cap_addr;
   logic [XLEN-1:0] cap_wdata;
   logic [2:0]      cap_funct3;
   logic            cap_write;
   mem2wb           wb_q, wb_d;
   dbus_req         req;

   logic            in_misalign;
   logic [7:0]      lane_wstrb;
   logic [XLEN-1:0] lane_wdata;
   logic [XLEN-1:0] load_data;

   mem_align u_align (
      .chk_addr   (in_addr[2:0]),
      .chk_size   (in_funct3[1:0]),
      .fmt_addr   (cap_addr[2:0]),
      .fmt_funct3 (cap_funct3),
      .fmt_write  (cap_write),
      .wdata      (cap_wdata),
      .rdata      (resp_rdata),
      .misalign   (in_misalign),
      .lane_wstrb (lane_wstrb),
      .lane_wdata (lane_wdata),
      .load_data  (load_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         kill_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         kill_q  <= kill_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      kill_d    = kill_q;
      mem_ready = 1'b1;
      req_valid = 1'b0;
      cap_en    = 1'b0;
      wb_d      = '0;
      unique case (state_q)
         IDLE: begin
            kill_d = 1'b0;
            if (in_valid && !mem_flush) begin
               if (!in_mem_en) begin
                  wb_d.valid  = 1'b1;
                  wb_d.result = in_alu_out;
               end else if (in_misalign) begin
                  wb_d.valid    = 1'b1;
                  wb_d.result   = in_addr;
                  wb_d.misalign = 1'b1;
               end else begin
                  mem_ready = 1'b0;
                  cap_en    = 1'b1;
                  state_d   = REQ;
               end
            end
         end
         REQ: begin
            mem_ready = 1'b0;
            req_valid = 1'b1;
            if (mem_flush) kill_d = 1'b1;
            if (req_ready) state_d = WAIT;
         end
         WAIT: begin
            mem_ready = resp_valid;
            if (mem_flush) kill_d = 1'b1;
            // A killed transaction still drains its response, then drops it.
            if (resp_valid) begin
               state_d = IDLE;
               kill_d  = 1'b0;
               if (!(kill_q || mem_flush)) begin
                  wb_d.valid  = 1'b1;
                  wb_d.result = cap_write ? '0 : load_data;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cap_addr   <= '0;
         cap_wdata  <= '0;
         cap_funct3 <= '0;
         cap_write  <= 1'b0;
      end else if (cap_en) begin
         cap_addr   <= in_addr;
         cap_wdata  <= in_wdata;
         cap_funct3 <= in_funct3;
         cap_write  <= in_mem_write;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) wb_q <= '0;
      else     wb_q <= wb_d;
   end

   always_comb begin
      req       = '0;
      req.addr  = {cap_addr[XLEN-1:3], 3'b000};
      req.write = cap_write;
      req.wstrb = lane_wstrb;
      req.wdata = lane_wdata;
   end

   assign req_addr     = req.addr;
   assign req_write    = req.write;
   assign req_wstrb    = req.wstrb;
   assign req_wdata    = req.wdata;
   assign out_valid    = wb_q.valid;
   assign out_result   = wb_q.result;
   assign out_misalign = wb_q.misalign;

endmodule

// File: tb/tb_stage_mem.sv
// Bench for stage_mem: directed scenarios with literal results, then
// random traffic checked every cycle against a transaction-level model.
module tb_stage_mem;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_flush;
   logic        in_valid;
   logic        in_mem_en;
   logic        in_mem_write;
   logic [2:0]  in_funct3;
   logic [63:0] in_addr;
   logic [63:0] in_wdata;
   logic [63:0] in_alu_out;
   logic        mem_ready;
   logic        req_valid;
   logic        req_ready;
   logic [63:0] req_addr;
   logic        req_write;
   logic [7:0]  req_wstrb;
   logic [63:0] req_wdata;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        out_valid;
   logic [63:0] out_result;
   logic        out_misalign;

   stage_mem dut (
      .clk          (clk),
      .rst          (rst),
      .mem_flush    (mem_flush),
      .in_valid     (in_valid),
      .in_mem_en    (in_mem_en),
      .in_mem_write (in_mem_write),
      .in_funct3    (in_funct3),
      .in_addr      (in_addr),
      .in_wdata     (in_wdata),
      .in_alu_out   (in_alu_out),
      .mem_ready    (mem_ready),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_addr     (req_addr),
      .req_write    (req_write),
      .req_wstrb    (req_wstrb),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .out_valid    (out_valid),
      .out_result   (out_result),
      .out_misalign (out_misalign)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] fmt_load(input logic [63:0] d,
                                            input logic [2:0] off,
                                            input logic [2:0] f3);
      int nb = 1 << f3[1:0];
      logic [63:0] v = d >> (8 * off);
      logic [63:0] r = '0;
      for (int i = 0; i < 64; i++)
         r[i] = (i < 8 * nb) ? v[i] : (f3[2] ? 1'b0 : v[8 * nb - 1]);
      return r;
   endfunction

   // Transaction-level model: is an access outstanding, has it been
   // granted, has it been killed, and what must the next write-back be.
   bit          m_busy, m_granted, m_killed;
   logic [63:0] p_addr, p_wdata;
   logic [2:0]  p_f3;
   logic        p_we;
   logic        e_v, e_mis;
   logic [63:0] e_res;
   bit          adv = 1'b1;
   logic        c_mis;
   int          c_nb;
   logic [7:0]  c_strb;

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_out_valid", out_valid, 0);
         chk("rst_out_result", out_result, 0);
         chk("rst_req_valid", req_valid, 0);
         m_busy = 0; m_granted = 0; m_killed = 0;
         e_v = 0; e_res = 0; e_mis = 0;
         adv = 1'b1;
      end else begin
         chk("m_out_valid", out_valid, e_v);
         chk("m_out_result", out_result, e_res);
         chk("m_out_misalign", out_misalign, e_mis);
         adv = mem_ready;
         e_v = 0; e_res = 0; e_mis = 0;
         if (!m_busy) begin
            c_mis = (in_addr % (64'd1 << in_funct3[1:0])) != 0;
            chk("m_req_valid_idle", req_valid, 0);
            chk("m_ready_idle", mem_ready,
                !(in_valid && in_mem_en && !c_mis && !mem_flush));
            if (in_valid && !mem_flush) begin
               if (!in_mem_en) begin
                  e_v = 1; e_res = in_alu_out;
               end else if (c_mis) begin
                  e_v = 1; e_res = in_addr; e_mis = 1;
               end else begin
                  m_busy = 1; m_granted = 0; m_killed = 0;
                  p_addr = in_addr; p_wdata = in_wdata;
                  p_f3 = in_funct3; p_we = in_mem_write;
               end
            end
         end else if (!m_granted) begin
            c_nb = 1 << p_f3[1:0];
            c_strb = '0;
            if (p_we)
               for (int i = 0; i < c_nb; i++) c_strb[p_addr[2:0] + i] = 1'b1;
            chk("m_req_valid", req_valid, 1);
            chk("m_ready_req", mem_ready, 0);
            chk("m_req_addr", req_addr, p_addr & ~64'd7);
            chk("m_req_write", req_write, p_we);
            chk("m_req_wstrb", req_wstrb, c_strb);
            if (p_we)
               chk("m_req_wdata", req_wdata, p_wdata << (8 * p_addr[2:0]));
            if (mem_flush) m_killed = 1;
            if (req_ready) m_granted = 1;
         end else begin
            chk("m_req_valid_wait", req_valid, 0);
            chk("m_ready_wait", mem_ready, resp_valid);
            if (mem_flush) m_killed = 1;
            if (resp_valid) begin
               m_busy = 0;
               if (!m_killed) begin
                  e_v = 1;
                  e_res = p_we ? 64'd0 : fmt_load(resp_rdata, p_addr[2:0], p_f3);
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_op(input string nm, input logic we, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] wd,
                        input logic [63:0] rd, input int stall, input bit fl,
                        input logic [63:0] x_addr, input logic [7:0] x_strb,
                        input logic [63:0] x_wlane, input logic x_ov,
                        input logic [63:0] x_res);
      int bad = 0;
      step();
      in_valid = 1; in_mem_en = 1; in_mem_write = we; in_funct3 = f3;
      in_addr = a; in_wdata = wd; req_ready = 0; resp_valid = 0;
      #1 chk({nm, "_ready_cap"}, mem_ready, 0);
      step();
      for (int i = 0; i <= stall; i++) begin
         req_ready = (i == stall);
         #1;
         if (!req_valid || mem_ready || req_addr !== x_addr ||
             req_wstrb !== x_strb || (we && req_wdata !== x_wlane))
            bad++;
         step();
      end
      chk({nm, "_req_stable"}, bad, 0);
      req_ready = 0; in_valid = 0;
      if (fl) begin
         mem_flush = 1;
         #1 chk({nm, "_ready_flush"}, mem_ready, 0);
         step();
         mem_flush = 0;
      end
      resp_valid = 1; resp_rdata = rd;
      #1 chk({nm, "_ready_resp"}, mem_ready, 1);
      step();
      resp_valid = 0;
      #1;
      chk({nm, "_out_valid"}, out_valid, x_ov);
      chk({nm, "_out_result"}, out_result, x_res);
   endtask

   task automatic alu_op(input string nm, input logic [63:0] v);
      step();
      in_valid = 1; in_mem_en = 0; in_alu_out = v;
      #1;
      chk({nm, "_ready"}, mem_ready, 1);
      chk({nm, "_req_valid"}, req_valid, 0);
      step();
      in_valid = 0;
      #1;
      chk({nm, "_out_valid"}, out_valid, 1);
      chk({nm, "_out_result"}, out_result, v);
      chk({nm, "_req_never"}, req_valid, 0);
   endtask

   int sz, off;

   initial begin
      rst = 1; mem_flush = 0; in_valid = 0; in_mem_en = 0; in_mem_write = 0;
      in_funct3 = 0; in_addr = 0; in_wdata = 0; in_alu_out = 0;
      req_ready = 0; resp_valid = 0; resp_rdata = 0;
      repeat (3) step();
      rst = 0;
      #1;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_result", out_result, 0);
      chk("reset_req_valid", req_valid, 0);
      chk("reset_mem_ready", mem_ready, 1);

      alu_op("alu", 64'h1234);

      do_op("lb", 0, 3'b000, 64'h1003, 0, 64'h0000_0000_8000_0000, 0, 0,
            64'h1000, 8'h00, 0, 1, 64'hFFFF_FFFF_FFFF_FF80);
      do_op("lbu", 0, 3'b100, 64'h1003, 0, 64'h0000_0000_8000_0000, 0, 0,
            64'h1000, 8'h00, 0, 1, 64'h80);
      do_op("sh", 1, 3'b001, 64'h2006, 64'hBEEF, 64'h1111, 3, 0,
            64'h2000, 8'hC0, 64'hBEEF_0000_0000_0000, 1, 0);

      step();
      in_valid = 1; in_mem_en = 1; in_mem_write = 0; in_funct3 = 3'b010;
      in_addr = 64'h1002;
      #1;
      chk("mis_ready", mem_ready, 1);
      chk("mis_req_valid", req_valid, 0);
      step();
      in_valid = 0;
      #1;
      chk("mis_out_valid", out_valid, 1);
      chk("mis_out_misalign", out_misalign, 1);
      chk("mis_out_result", out_result, 64'h1002);
      chk("mis_req_never", req_valid, 0);

      do_op("flush_ld", 0, 3'b011, 64'h3000, 0, 64'hDEAD_BEEF_0123_4567, 1, 1,
            64'h3000, 8'h00, 0, 0, 0);
      alu_op("after_flush", 64'h55);
      do_op("ld", 0, 3'b011, 64'h3008, 0, 64'hDEAD_BEEF_0123_4567, 0, 0,
            64'h3008, 8'h00, 0, 1, 64'hDEAD_BEEF_0123_4567);

      step();
      in_valid = 1; in_mem_en = 1; in_mem_write = 0; in_funct3 = 3'b011;
      in_addr = 64'h4000;
      step();
      in_valid = 0;
      #1 chk("rstreq_req_valid_before", req_valid, 1);
      rst = 1;
      #1;
      chk("rstreq_req_valid", req_valid, 0);
      chk("rstreq_out_valid", out_valid, 0);
      step();
      rst = 0;
      #1;
      chk("rstreq_ready_after", mem_ready, 1);
      chk("rstreq_req_after", req_valid, 0);

      repeat (3000) begin
         step();
         if (adv) begin
            in_valid = ($urandom % 5) != 0;
            in_mem_en = ($urandom % 3) != 0;
            in_mem_write = $urandom % 2;
            in_funct3 = 3'($urandom);
            sz = in_funct3[1:0];
            off = $urandom % 8;
            if (($urandom % 5) != 0) off = off & ~((1 << sz) - 1);
            in_addr = ({32'h0, $urandom} & ~64'd7) | 64'(off);
            in_wdata = {$urandom, $urandom};
            in_alu_out = {$urandom, $urandom};
         end
         mem_flush = ($urandom % 10) == 0;
         req_ready = ($urandom % 3) != 0;
         resp_valid = ($urandom % 3) == 0;
         resp_rdata = {$urandom, $urandom};
      end
      in_valid = 0; mem_flush = 0; req_ready = 1; resp_valid = 1;
      repeat (4) step();
      resp_valid = 0;
      repeat (2) step();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/stage_mem.md
# stage_mem

Memory-access pipeline stage that sits directly downstream of the execute stage. It takes the execute stage's bypassed address, store data, funct3 and ALU result, runs one load/store transaction per instruction on a valid/ready data-cache bus, and aligns and sign-extends load data. It produces a registered result for write-back and back-pressures the pipeline through `mem_ready` while a transaction is outstanding.

## Interface
Parameters: none (XLEN fixed at 64).

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mem_flush` in 1: kill the instruction currently in this stage.
- `in_valid` in 1: an instruction is presented by execute.
- `in_mem_en`, `in_mem_write` in 1 each: memory op present; store when 1, load when 0.
- `in_funct3` in 3: bits [1:0] are the size (0=B, 1=H, 2=W, 3=D); bit [2] set means unsigned load.
- `in_addr` in 64: effective address (rs1+imm).
- `in_wdata` in 64: store data (rs2).
- `in_alu_out` in 64: ALU result for non-memory instructions.
- `mem_ready` out 1: stage can accept the next instruction in this cycle.
- `req_valid` out 1, `req_ready` in 1: data-bus request handshake.
- `req_addr` out 64: `{addr[63:3],3'b0}`.
- `req_write` out 1: 1 for a store request.
- `req_wstrb` out 8: byte-write strobes for a store.
- `req_wdata` out 64: store data shifted into its byte lanes.
- `resp_valid` in 1: one-cycle response pulse.
- `resp_rdata` in 64: response data.
- `out_valid` out 1: registered result is valid for write-back.
- `out_result` out 64: ALU result, formatted load data, or the faulting address.
- `out_misalign` out 1: misaligned-access exception flag.

## Operation
- FSM states are IDLE, REQ and WAIT. The reset state is IDLE. At reset all outputs are 0 and all capture registers are cleared.
- **Misalignment:** an access is misaligned when `addr` is not a multiple of `1<<size`. H needs `addr[0]==0`, W needs `addr[1:0]==0`, D needs `addr[2:0]==0`.
- **IDLE, non-memory op** (`in_valid & ~in_mem_en`):
  - `mem_ready=1`.
  - Next edge: `out_valid=1`, `out_result=in_alu_out`, `out_misalign=0`.
- **IDLE, misaligned memory op:**
  - `mem_ready=1`; no bus request is issued.
  - Next edge: `out_valid=1`, `out_misalign=1`, `out_result=in_addr`.
- **IDLE, aligned memory op:**
  - `mem_ready=0`.
  - Capture the address, funct3, write flag and store data, then go to REQ.
- **REQ:**
  - `req_valid=1`, driven from the capture registers.
  - Once asserted, `req_valid` and the request fields stay stable until `req_ready`.
  - Handshake (`req_valid & req_ready`) moves the FSM to WAIT.
- **WAIT:**
  - On `resp_valid`: `mem_ready=1` that cycle, and the FSM returns to IDLE.
  - Next edge: `out_valid=1`. For a load, `out_result` is the formatted data; for a store, `out_result=0`.
- **Load formatting:**
  - Shift: `resp_rdata >> (8*addr[2:0])`.
  - Then take the low 8/16/32/64 bits.
  - Zero-extend when `funct3[2]`, otherwise sign-extend.
- **Store formatting:**
  - `req_wdata = wdata << (8*addr[2:0])`.
  - `req_wstrb = {1,3,15,255}[size] << addr[2:0]`.
  - `req_wstrb = 0` for loads.
- **Flush:**
  - In IDLE: the input is dropped and the next `out_valid=0`.
  - In REQ or WAIT: a request is never withdrawn. A kill bit is set, the transaction runs to its response, and the completion edge writes `out_valid=0`.
  - The kill bit clears on return to IDLE.
- **Idle cycle** (`~in_valid`): `mem_ready=1` and the next `out_valid=0`.
- `resp_valid` outside WAIT is ignored. `req_ready` outside REQ is ignored.

## Timing
- Non-memory and misaligned ops take 1 cycle (input to registered output).
- Aligned memory op, best case (`req_ready` high immediately, response the next cycle):
  - Cycle 0: capture.
  - Cycle 1: REQ and handshake.
  - Cycle 2: WAIT with `resp_valid`.
  - Result on the edge ending cycle 2, so 3 cycles total.
- The result appears at the edge ending the `resp_valid` cycle.
- `mem_ready` is combinational from the state, the inputs and `resp_valid`; it has no path from `req_ready`.
- Reset asserted mid-REQ or mid-WAIT: the FSM goes to IDLE immediately and all outputs go to 0. The bus owner must also reset.

## Structure
- Shared package:
  - `mem_state_t` enum (IDLE/REQ/WAIT).
  - Size encodings `SZ_B`/`SZ_H`/`SZ_W`/`SZ_D`.
  - `dbus_req` packed struct (addr, write, wstrb, wdata).
  - `mem2wb` packed struct (valid, result, misalign).
- Sub-module `mem_align`, purely combinational: misalignment check, store lane shift and strobe, load shift and extension.

## Test plan
- **ALU passthrough:** `in_valid=1`, `mem_en=0`, `alu_out=0x1234` → `mem_ready=1`; next cycle `out_valid=1`, `out_result=0x1234`; `req_valid` never rises.
- **LB / LBU:** `addr=0x1003`, `resp_rdata=0x0000_0000_8000_0000`.
  - LB → `out_result=0xFFFF_FFFF_FFFF_FF80`.
  - LBU → `out_result=0x80`.
  - `req_addr=0x1000`.
- **SH with back-pressure:** `addr=0x2006`, `wdata=0xBEEF`, `req_ready` low for 3 cycles.
  - `req_valid` and fields stay stable throughout.
  - `req_wstrb=0xC0`, `req_wdata=0xBEEF_0000_0000_0000`.
  - `mem_ready=0` until `resp_valid`.
- **Misaligned LW:** `addr=0x1002` → no `req_valid`; next cycle `out_misalign=1`, `out_result=0x1002`.
- **Flush in WAIT:** LD issued, then `mem_flush` pulsed in WAIT → response is still consumed; completion `out_valid=0`; the next op proceeds normally.
- **Reset in REQ:** `rst` pulsed while `req_valid=1` → `req_valid`, `out_valid` and `mem_ready` state clear immediately; FSM is in IDLE and `mem_ready=1` after release.
